// File: rtl/approx_mult_scheduler.sv
// Round-robin scheduler feeding a shared LAT-stage approximate signed multiplier.
// Optional correction counter is enabled by defining APPROX_SCHED_STATS_EN.
module approx_mult_scheduler #(
  parameter int WIDTH                = 32,
  parameter int N_REQ                = 4,
  parameter int LAT                  = 3,
  parameter int ERROR_RECOVERY_LEVEL = 1,
  localparam int IDW                 = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  input  logic [N_REQ-1:0]         req_recover,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_y,
  output logic                     busy
`ifdef APPROX_SCHED_STATS_EN
  , output logic [31:0]            corr_count
`endif
);

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) begin
      s = s - N_REQ;
    end else begin
      s = s;
    end
    return IDW'(s);
  endfunction

  function automatic logic [WIDTH-1:0] recover_fn(input logic [WIDTH-1:0] p, input logic en);
    if ((ERROR_RECOVERY_LEVEL >= 1) && en && p[WIDTH-1]) begin
      return p + WIDTH'(1);
    end else begin
      return p;
    end
  endfunction

  logic                     stall_s, found_s, issue_s;
  logic [IDW-1:0]           grant_s;
  logic [IDW-1:0]           ptr_q, ptr_d;
  logic [WIDTH-1:0]         a_s, b_s;
  logic signed [WIDTH-1:0]  prod_s;

  logic                     v_q   [LAT];
  logic                     v_d   [LAT];
  logic [WIDTH-1:0]         p_q   [LAT];
  logic [WIDTH-1:0]         p_d   [LAT];
  logic [IDW-1:0]           id_q  [LAT];
  logic [IDW-1:0]           id_d  [LAT];
  logic                     r_q   [LAT];
  logic                     r_d   [LAT];

  logic                     in_v  [LAT];
  logic [WIDTH-1:0]         in_p  [LAT];
  logic [IDW-1:0]           in_id [LAT];
  logic                     in_r  [LAT];

`ifdef APPROX_SCHED_STATS_EN
  logic                     corr_q, corr_d;
  logic [31:0]              cnt_q, cnt_d;
`endif

  assign stall_s   = rsp_valid && !rsp_ready;
  assign rsp_valid = v_q[LAT-1];
  assign rsp_y     = p_q[LAT-1];
  assign rsp_id    = id_q[LAT-1];

  // Round-robin grant search starting at ptr
  always_comb begin
    found_s = 1'b0;
    grant_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found_s && req_valid[wrap_idx(ptr_q, k)]) begin
        found_s = 1'b1;
        grant_s = wrap_idx(ptr_q, k);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign issue_s = found_s && !stall_s && !rst;

  // One-hot ready for the granted requester
  always_comb begin
    req_ready = '0;
    if (issue_s) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Low WIDTH bits of the signed product equal the truncated full product
  assign a_s    = req_a[int'(grant_s)*WIDTH +: WIDTH];
  assign b_s    = req_b[int'(grant_s)*WIDTH +: WIDTH];
  assign prod_s = $signed(a_s) * $signed(b_s);

  // Stage inputs: stage 0 from the issuing requester, later stages from the previous register
  always_comb begin
    in_v[0]  = issue_s;
    in_p[0]  = prod_s;
    in_id[0] = grant_s;
    in_r[0]  = req_recover[grant_s];
    for (int k = 1; k < LAT; k++) begin
      in_v[k]  = v_q[k-1];
      in_p[k]  = p_q[k-1];
      in_id[k] = id_q[k-1];
      in_r[k]  = r_q[k-1];
    end
  end

  // Next state: shift when unstalled, recovery applied as the output stage loads
  always_comb begin
    for (int k = 0; k < LAT; k++) begin
      v_d[k]  = v_q[k];
      p_d[k]  = p_q[k];
      id_d[k] = id_q[k];
      r_d[k]  = r_q[k];
    end
    ptr_d = ptr_q;
`ifdef APPROX_SCHED_STATS_EN
    corr_d = corr_q;
    cnt_d  = cnt_q;
`endif
    if (!stall_s) begin
      for (int k = 0; k < LAT; k++) begin
        v_d[k]  = in_v[k];
        p_d[k]  = in_p[k];
        id_d[k] = in_id[k];
        r_d[k]  = in_r[k];
      end
      p_d[LAT-1] = recover_fn(in_p[LAT-1], in_r[LAT-1]);
`ifdef APPROX_SCHED_STATS_EN
      corr_d = (recover_fn(in_p[LAT-1], in_r[LAT-1]) != in_p[LAT-1]);
`endif
    end else begin
      ptr_d = ptr_q;
    end
    if (issue_s) begin
      ptr_d = wrap_idx(grant_s, 1);
    end else begin
      ptr_d = ptr_q;
    end
`ifdef APPROX_SCHED_STATS_EN
    if (rsp_valid && rsp_ready && corr_q && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
`endif
  end

  // Pipeline, pointer and statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      for (int k = 0; k < LAT; k++) begin
        v_q[k]  <= 1'b0;
        p_q[k]  <= '0;
        id_q[k] <= '0;
        r_q[k]  <= 1'b0;
      end
`ifdef APPROX_SCHED_STATS_EN
      corr_q <= 1'b0;
      cnt_q  <= 32'd0;
`endif
    end else begin
      ptr_q <= ptr_d;
      for (int k = 0; k < LAT; k++) begin
        v_q[k]  <= v_d[k];
        p_q[k]  <= p_d[k];
        id_q[k] <= id_d[k];
        r_q[k]  <= r_d[k];
      end
`ifdef APPROX_SCHED_STATS_EN
      corr_q <= corr_d;
      cnt_q  <= cnt_d;
`endif
    end
  end

  // Any stage occupied, output register included
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      busy = busy | v_q[k];
    end
  end

`ifdef APPROX_SCHED_STATS_EN
  assign corr_count = cnt_q;
`endif

endmodule

// File: tb/tb_approx_mult_scheduler.sv
// Scoreboard bench for approx_mult_scheduler: driver predicts grants and results,
// a separate monitor pops and compares every response handshake.
module tb_approx_mult_scheduler;
  localparam int WIDTH = 32;
  localparam int N_REQ = 4;
  localparam int LAT   = 3;
  localparam int ERL   = 1;
  localparam int IDW   = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a, req_b;
  logic [N_REQ-1:0]       req_recover;
  logic                   rsp_valid, rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [WIDTH-1:0]       rsp_y;
  logic                   busy;
`ifdef APPROX_SCHED_STATS_EN
  logic [31:0]            corr_count;
`endif

  approx_mult_scheduler #(.WIDTH(WIDTH), .N_REQ(N_REQ), .LAT(LAT), .ERROR_RECOVERY_LEVEL(ERL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_recover(req_recover),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .busy(busy)
`ifdef APPROX_SCHED_STATS_EN
    , .corr_count(corr_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] y;
    bit               corr;
    int               icyc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_ptr = 0;
  int   model_corr = 0;
  bit   lat_strict = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: truncated signed product, then +1 on negative results when recovery is requested
  task automatic ref_calc(input logic [31:0] a, input logic [31:0] b, input bit rec,
                          output logic [31:0] y, output bit corr);
    longint p;
    int     r;
    p = longint'($signed(a)) * longint'($signed(b));
    r = int'(p);
    corr = 1'b0;
    if (ERL >= 1 && rec && r < 0) begin
      r = r + 1;
      corr = 1'b1;
    end
    y = r;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 16)) - 32'd8;
      1:       return $urandom();
      2:       return 32'h8000_0000 ^ 32'($urandom_range(0, 3));
      default: return 32'($urandom_range(0, 100));
    endcase
  endfunction

  // Called with inputs already applied just after a falling edge; returns at the next falling edge
  task automatic tick();
    int               g;
    bit               stall;
    logic [N_REQ-1:0] exp_rdy;
    exp_t             e;
    #1;
    g = -1;
    exp_rdy = '0;
    stall = (rsp_valid === 1'b1) && !rsp_ready;
    if (rst) begin
      model_ptr = 0;
      model_corr = 0;
      sbq.delete();
    end else if (!stall) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (g < 0 && req_valid[(model_ptr + k) % N_REQ]) g = (model_ptr + k) % N_REQ;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (g >= 0) begin
      e.id = IDW'(g);
      ref_calc(req_a[g*WIDTH +: WIDTH], req_b[g*WIDTH +: WIDTH], req_recover[g], e.y, e.corr);
      e.icyc = cyc + 1;
      sbq.push_back(e);
      model_ptr = (g + 1) % N_REQ;
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input bit rec);
    req_valid[i] = 1'b1;
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_recover[i] = rec;
  endtask

  task automatic all_rand(input logic [N_REQ-1:0] mask);
    req_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (mask[i]) set_req(i, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic one(input int i, input logic [31:0] a, input logic [31:0] b, input bit rec);
    req_valid = '0;
    set_req(i, a, b, rec);
    tick();
    req_valid = '0;
  endtask

  task automatic drain();
    int t;
    req_valid = '0;
    rsp_ready = 1'b1;
    t = 0;
    while ((sbq.size() != 0 || busy) && t < 200) begin
      tick();
      t++;
    end
    tick();
    chk("drain_queue_empty", 64'(sbq.size()), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  // Monitor: compares each response handshake and checks hold behaviour under backpressure
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_y;
  logic [IDW-1:0]   prev_id;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", 64'(rsp_valid), 64'd1);
        chk("stall_y_held", 64'(rsp_y), 64'(prev_y));
        chk("stall_id_held", 64'(rsp_id), 64'(prev_id));
      end
      if (rsp_valid === 1'b1 && rsp_ready) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got id=%0d y=%0h expected none", rsp_id, rsp_y);
        end else begin
          e = sbq.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_y", 64'(rsp_y), 64'(e.y));
          if (lat_strict) chk("latency", 64'(cyc - e.icyc + 1), 64'(LAT));
          if (e.corr) model_corr++;
        end
      end
      prev_stall = (rsp_valid === 1'b1) && !rsp_ready;
      prev_y = rsp_y;
      prev_id = rsp_id;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_recover = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    tick();
    tick();
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_rsp_y", 64'(rsp_y), 64'd0);
    rst = 1'b0;

    // Directed single-requester cases with exact latency
    lat_strict = 1'b1;
    one(0, 32'd3, -32'sd4, 1'b1);
    drain();
    one(0, 32'd3, -32'sd4, 1'b0);
    drain();
    one(0, 32'd1, -32'sd1, 1'b1);
    one(0, 32'h4000_0000, 32'd4, 1'b1);
    drain();

    // All four continuously, then requester 2 alone
    for (int n = 0; n < 6; n++) begin
      all_rand(4'b1111);
      tick();
    end
    for (int n = 0; n < 4; n++) begin
      all_rand(4'b0100);
      tick();
    end
    drain();

    // Back-to-back issues with a 5-cycle response stall
    lat_strict = 1'b0;
    for (int n = 0; n < 8; n++) begin
      all_rand(4'b1111);
      rsp_ready = (n < 3);
      tick();
    end
    drain();

    // Reset with entries in flight
    for (int n = 0; n < LAT; n++) begin
      all_rand(4'b1111);
      tick();
    end
    rst = 1'b1;
    tick();
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    all_rand(4'b1111);
    tick();
    drain();

    // Randomized traffic with random backpressure
    for (int n = 0; n < 400; n++) begin
      all_rand(4'($urandom_range(0, 15)));
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain();

`ifdef APPROX_SCHED_STATS_EN
    chk("corr_count_random", 64'(corr_count), 64'(model_corr));
    rst = 1'b1;
    tick();
    chk("corr_count_reset", 64'(corr_count), 64'd0);
    rst = 1'b0;
    one(2, -32'sd3, 32'd2, 1'b1);
    one(1, -32'sd7, 32'd1, 1'b1);
    one(3, -32'sd5, 32'd5, 1'b1);
    one(0, 32'd2, 32'd3, 1'b1);
    drain();
    chk("corr_count_directed", 64'(corr_count), 64'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
